// File: rtl/seg_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_if
//
// Bundles every non-clock, non-reset signal of the seven-segment scan
// controller into one interface.
//
//   Display-register side (master drives, controller reads):
//     en          scan enable; 0 keeps the display dark
//     digits      one hex nibble per digit, digit i = digits[4i+3:4i]
//     dp          decimal point per digit, 1 = lit
//     blank_mask  1 = digit i is never lit
//     brightness  lit ticks per 8-tick slot, 0..7
//     tick        one-cycle pulse from the clk_div tick generator
//
//   Controller outputs (controller drives, master reads):
//     div_rst     active-high reset for clk_div
//     clk_divider divide value for clk_div
//     an          anode enables, active-low, bit i = digit i
//     seg         segments {g,f,e,d,c,b,a}, active-low
//     dp_n        decimal point, active-low
//     frame_done  one-cycle pulse when the last digit's slot ends
// -----------------------------------------------------------------------------
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [2:0]              brightness;
    logic                    tick;

    logic                    div_rst;
    logic [31:0]             clk_divider;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp_n;
    logic                    frame_done;

    // The register-file / tick-source side of the link.
    modport master (
        output en, digits, dp, blank_mask, brightness, tick,
        input  div_rst, clk_divider, an, seg, dp_n, frame_done
    );

    // The scan controller itself.
    modport slave (
        input  en, digits, dp, blank_mask, brightness, tick,
        output div_rst, clk_divider, an, seg, dp_n, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Scan controller for a multiplexed common-anode seven-segment display.
// It holds the clk_div tick generator in reset while the display is off,
// releases it when scanning is enabled, and uses its one-cycle tick to walk
// through NUM_DIGITS digits. Every digit owns an 8-tick slot: the first
// `brightness` ticks are lit, the remaining ticks are dark, and since
// brightness tops out at 7 there is always at least one dark tick before the
// next anode turns on, which keeps neighbouring digits from ghosting.
//
// Ports:
//   clk_in   single clock, everything on its rising edge
//   RST_N    synchronous active-low reset
//   bus      seg_scan_ctrl_if slave modport (inputs from the display
//            register file and the tick; anode/segment/divider outputs)
//
// Parameters:
//   NUM_DIGITS  number of multiplexed digits, 2..8
//   SCAN_DIV    value presented on clk_divider; tick period = SCAN_DIV+1
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int          NUM_DIGITS = 4,
    parameter logic [31:0] SCAN_DIV   = 32'd6249
) (
    input logic            clk_in,
    input logic            RST_N,
    seg_scan_ctrl_if.slave bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_SYNC,
        S_LIT,
        S_DARK
    } state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [2:0]            slot_cnt;
    logic [2:0]            bright_lat;

    logic                  last_digit;
    logic                  slot_start;
    logic [IDX_W-1:0]      start_idx;
    logic [3:0]            start_digit;
    logic                  start_dp;
    logic                  start_mask;
    logic [2:0]            start_bright;
    logic                  start_lit;
    logic [NUM_DIGITS-1:0] start_an;
    logic [6:0]            start_seg;

    // Hex nibble to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Everything the FSM needs at the start of a slot: which digit comes
    // next, that digit's nibble/dp/mask as seen on the inputs right now,
    // and the brightness that will govern it. A slot starts either on the
    // first tick after leaving SYNC (always digit 0) or on the tick that
    // ends slot position 7. Brightness is only re-sampled when the next
    // slot is digit 0, so one frame always uses a single brightness.
    always_comb begin
        last_digit = (idx == LAST_IDX);

        slot_start = 1'b0;
        if (bus.tick) begin
            if (state == S_SYNC) begin
                slot_start = 1'b1;
            end else if ((state == S_LIT || state == S_DARK) && slot_cnt == 3'd7) begin
                slot_start = 1'b1;
            end
        end

        start_idx = '0;
        if (state != S_SYNC && !last_digit) begin
            start_idx = idx + IDX_W'(1);
        end

        start_digit  = bus.digits[{start_idx, 2'b00} +: 4];
        start_dp     = bus.dp[start_idx];
        start_mask   = bus.blank_mask[start_idx];
        start_bright = (start_idx == '0) ? bus.brightness : bright_lat;
        start_lit    = (start_bright != 3'd0) && !start_mask;
        start_an     = ~(NUM_DIGITS'(1) << start_idx);
        start_seg    = hex_to_seg(start_digit);
    end

    // Scan FSM with all outputs registered. The anode/segment registers
    // double as the per-slot latch of the digit: they are loaded once at
    // slot start and only ever go dark afterwards, so input changes inside
    // a slot cannot reach the pins until the next slot begins.
    // Dropping en wins over everything else, including a coincident tick,
    // and clears the position so the next enable restarts at digit 0.
    always_ff @(posedge clk_in) begin
        if (!RST_N) begin
            state           <= S_OFF;
            idx             <= '0;
            slot_cnt        <= 3'd0;
            bright_lat      <= 3'd0;
            bus.an          <= '1;
            bus.seg         <= 7'h7F;
            bus.dp_n        <= 1'b1;
            bus.frame_done  <= 1'b0;
            bus.div_rst     <= 1'b1;
            bus.clk_divider <= SCAN_DIV;
        end else begin
            bus.frame_done  <= 1'b0;
            bus.clk_divider <= SCAN_DIV;

            if (!bus.en) begin
                state       <= S_OFF;
                idx         <= '0;
                slot_cnt    <= 3'd0;
                bus.div_rst <= 1'b1;
                bus.an      <= '1;
                bus.seg     <= 7'h7F;
                bus.dp_n    <= 1'b1;
            end else if (state == S_OFF) begin
                state       <= S_SYNC;
                bus.div_rst <= 1'b0;
            end else if (slot_start) begin
                idx      <= start_idx;
                slot_cnt <= 3'd0;
                if (start_idx == '0) begin
                    bright_lat <= start_bright;
                end
                if (state != S_SYNC && last_digit) begin
                    bus.frame_done <= 1'b1;
                end
                if (start_lit) begin
                    state    <= S_LIT;
                    bus.an   <= start_an;
                    bus.seg  <= start_seg;
                    bus.dp_n <= ~start_dp;
                end else begin
                    state    <= S_DARK;
                    bus.an   <= '1;
                    bus.seg  <= 7'h7F;
                    bus.dp_n <= 1'b1;
                end
            end else if (bus.tick && state != S_SYNC) begin
                slot_cnt <= slot_cnt + 3'd1;
                // On-time ends once the slot position reaches brightness.
                if (state == S_LIT && (slot_cnt + 3'd1) == bright_lat) begin
                    state    <= S_DARK;
                    bus.an   <= '1;
                    bus.seg  <= 7'h7F;
                    bus.dp_n <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4. A free-running
// generator stands in for clk_div and pulses tick every 4 clocks. Outputs
// are sampled on the falling edge; expected values are hand-derived
// segment codes and slot/brightness rules.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int          NUM_DIGITS = 4;
    localparam logic [31:0] SCAN_DIV   = 32'd6249;

    // Segment codes for digits 16'h4321 listed {digit3, digit2, digit1, digit0}.
    localparam logic [27:0] SEGS_4321 = {7'h19, 7'h30, 7'h24, 7'h79};

    logic clk_in;
    logic RST_N;
    int   assertionCount = 0;
    int   failureCount   = 0;
    int   tickPhase;

    seg_scan_ctrl_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS(NUM_DIGITS),
        .SCAN_DIV  (SCAN_DIV)
    ) dut (
        .clk_in(clk_in),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // 10 ns clock.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Stand-in for clk_div: one-cycle tick every 4 clocks, changing 1 ns
    // after the rising edge so the DUT samples it cleanly.
    initial begin
        bus.tick  = 1'b0;
        tickPhase = 0;
        forever begin
            @(posedge clk_in);
            #1;
            tickPhase = (tickPhase + 1) % 4;
            bus.tick  = (tickPhase == 0);
        end
    end

    // Hard stop in case something wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no end of test, required end before 500000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic enV, input logic [15:0] digitsV,
                                 input logic [3:0] dpV, input logic [3:0] maskV,
                                 input logic [2:0] brightV);
        bus.en         = enV;
        bus.digits     = digitsV;
        bus.dp         = dpV;
        bus.blank_mask = maskV;
        bus.brightness = brightV;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertionCount++;
        assert (observed === expected)
        else begin
            failureCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to a falling edge at which tick is high (it will be consumed
    // at the next rising edge). Bounded so a dead tick source cannot hang.
    task automatic waitTick();
        int n;
        n = 0;
        while (bus.tick !== 1'b1 && n < 16) begin
            @(negedge clk_in);
            n++;
        end
        if (bus.tick !== 1'b1) begin
            checkOutput("tick timeout", 32'(bus.tick), 32'd1);
        end
    endtask

    // Let one tick be consumed, then sample on the following falling edge.
    task automatic stepTick();
        waitTick();
        @(negedge clk_in);
    endtask

    // Check slot positions fromPos..toPos of digit idx; the caller is already
    // sitting at fromPos.
    task automatic runSlot(input int idx, input logic [6:0] segVal, input logic dpNVal,
                           input int bright, input logic masked,
                           input int fromPos, input int toPos);
        logic       lit;
        logic [3:0] expAn;
        logic [6:0] expSeg;
        logic       expDpN;
        for (int pos = fromPos; pos <= toPos; pos++) begin
            if (pos > fromPos) stepTick();
            lit    = !masked && (pos < bright);
            expAn  = lit ? ~(4'b0001 << idx) : 4'hF;
            expSeg = lit ? segVal : 7'h7F;
            expDpN = lit ? dpNVal : 1'b1;
            checkOutput($sformatf("d%0d p%0d an", idx, pos), 32'(bus.an), 32'(expAn));
            checkOutput($sformatf("d%0d p%0d seg", idx, pos), 32'(bus.seg), 32'(expSeg));
            checkOutput($sformatf("d%0d p%0d dp_n", idx, pos), 32'(bus.dp_n), 32'(expDpN));
            checkOutput($sformatf("d%0d p%0d frame_done", idx, pos), 32'(bus.frame_done), 32'd0);
        end
    endtask

    // Cross a slot boundary: outputs must still be dark while the ending
    // tick is pending, change exactly one clock later, and frame_done must
    // be a single-clock pulse after the last digit.
    task automatic slotBoundary(input logic lastDigit);
        waitTick();
        checkOutput("pre-edge an", 32'(bus.an), 32'hF);
        checkOutput("pre-edge frame_done", 32'(bus.frame_done), 32'd0);
        @(negedge clk_in);
        if (lastDigit) begin
            checkOutput("frame_done pulse", 32'(bus.frame_done), 32'd1);
            @(negedge clk_in);
            checkOutput("frame_done width", 32'(bus.frame_done), 32'd0);
        end
    endtask

    // One full frame starting at digit 0, slot position 0.
    task automatic runFrame(input logic [27:0] segs, input logic [3:0] dpv,
                            input logic [3:0] maskv, input int bright);
        logic [6:0] s;
        logic       dn;
        for (int i = 0; i < 4; i++) begin
            s  = segs[7*i +: 7];
            dn = ~dpv[i];
            runSlot(i, s, dn, bright, maskv[i], 0, 7);
            slotBoundary(i == 3);
        end
    endtask

    initial begin
        // Reset held for 3 clocks with en=1 and ticks running.
        RST_N = 1'b0;
        applyStimulus(1'b1, 16'h4321, 4'b0000, 4'b0000, 3'd7);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        checkOutput("reset an", 32'(bus.an), 32'hF);
        checkOutput("reset seg", 32'(bus.seg), 32'h7F);
        checkOutput("reset dp_n", 32'(bus.dp_n), 32'd1);
        checkOutput("reset div_rst", 32'(bus.div_rst), 32'd1);
        checkOutput("reset frame_done", 32'(bus.frame_done), 32'd0);
        checkOutput("reset clk_divider", bus.clk_divider, 32'd6249);

        // Release: one clock later the divider comes out of reset.
        RST_N = 1'b1;
        @(negedge clk_in);
        checkOutput("div_rst fall", 32'(bus.div_rst), 32'd0);
        checkOutput("sync an", 32'(bus.an), 32'hF);
        checkOutput("clk_divider", bus.clk_divider, 32'd6249);
        waitTick();
        checkOutput("sync pre-tick an", 32'(bus.an), 32'hF);
        @(negedge clk_in);

        // Frame 1: full brightness, 1/2/3/4 on digits 0..3.
        runFrame(SEGS_4321, 4'b0000, 4'b0000, 7);

        // Brightness 0 requested mid-frame: frame 2 keeps 7, frame 3 is dark.
        applyStimulus(1'b1, 16'h4321, 4'b0000, 4'b0000, 3'd0);
        runFrame(SEGS_4321, 4'b0000, 4'b0000, 7);

        // Brightness 3 plus mask/dp requested during the dark frame.
        applyStimulus(1'b1, 16'h4321, 4'b0001, 4'b0100, 3'd3);
        runFrame(SEGS_4321, 4'b0000, 4'b0000, 0);
        runFrame(SEGS_4321, 4'b0001, 4'b0100, 3);

        // Mask/dp cleared and brightness 7 requested in digit 0 of frame 5:
        // digit 0 keeps its dp and frame 5 keeps brightness 3, digit 2 returns.
        applyStimulus(1'b1, 16'h4321, 4'b0000, 4'b0000, 3'd7);
        runFrame(SEGS_4321, 4'b0001, 4'b0000, 3);

        // Frame 6: digit 0 nibble changes on its 3rd lit tick; no visible effect.
        runSlot(0, 7'h79, 1'b1, 7, 1'b0, 0, 2);
        applyStimulus(1'b1, 16'h4329, 4'b0000, 4'b0000, 3'd7);
        runSlot(0, 7'h79, 1'b1, 7, 1'b0, 2, 7);
        slotBoundary(1'b0);
        runSlot(1, 7'h24, 1'b1, 7, 1'b0, 0, 7);
        slotBoundary(1'b0);
        runSlot(2, 7'h30, 1'b1, 7, 1'b0, 0, 7);
        slotBoundary(1'b0);
        runSlot(3, 7'h19, 1'b1, 7, 1'b0, 0, 7);
        slotBoundary(1'b1);

        // Frame 7: digit 0 now shows 9.
        runSlot(0, 7'h10, 1'b1, 7, 1'b0, 0, 7);
        slotBoundary(1'b0);
        runSlot(1, 7'h24, 1'b1, 7, 1'b0, 0, 0);

        // Drop en together with a tick while digit 1 is lit.
        waitTick();
        applyStimulus(1'b0, 16'h4329, 4'b0000, 4'b0000, 3'd7);
        @(negedge clk_in);
        checkOutput("off an", 32'(bus.an), 32'hF);
        checkOutput("off seg", 32'(bus.seg), 32'h7F);
        checkOutput("off dp_n", 32'(bus.dp_n), 32'd1);
        checkOutput("off div_rst", 32'(bus.div_rst), 32'd1);
        checkOutput("off frame_done", 32'(bus.frame_done), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            checkOutput($sformatf("off hold %0d an", k), 32'(bus.an), 32'hF);
            checkOutput($sformatf("off hold %0d frame_done", k), 32'(bus.frame_done), 32'd0);
        end

        // Re-enable: divider released next clock, scan restarts at digit 0.
        applyStimulus(1'b1, 16'h4329, 4'b0000, 4'b0000, 3'd7);
        @(negedge clk_in);
        checkOutput("re-enable div_rst", 32'(bus.div_rst), 32'd0);
        checkOutput("re-enable an", 32'(bus.an), 32'hF);
        waitTick();
        checkOutput("re-enable pre-tick an", 32'(bus.an), 32'hF);
        @(negedge clk_in);
        checkOutput("restart an", 32'(bus.an), 32'hE);
        checkOutput("restart seg", 32'(bus.seg), 32'h10);
        checkOutput("restart dp_n", 32'(bus.dp_n), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertionCount, failureCount);
        $finish;
    end

endmodule
